aes_top: RTL and testbench

Iterative AES-128 encryption core: takes one 128-bit plaintext block and a 128-bit cipher key, and produces the FIPS-197 ciphertext. It computes one round per clock with on-the-fly key expansion. It is the top-level crypto datapath, driven by a simple enable/valid handshake from the surrounding controller. Decryption is out of scope.

---
 rtl/aes_top.sv | 168 ++++++++++++++++
 tb/tb_aes_top.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_top.sv
// Iterative AES-128 encryption core.
// One round per clock with on-the-fly key expansion.
module aes_top (
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {IDLE, BUSY} fsm_t;

  fsm_t         fsm, fsm_nx;
  logic [127:0] state_reg, state_nx;
  logic [127:0] key_reg, key_nx;
  logic [127:0] out_nx;
  logic [3:0]   rnd, rnd_nx;
  logic         vld_nx;
  logic [127:0] next_key;
  logic [127:0] sr;

  // byte 0 of the table sits in the top bits
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // byte r+4c of the state is row r, column c
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] =
          sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {
        xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
        xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)
      };
    end
    return o;
  endfunction

  function automatic logic [127:0] key_exp(
    input logic [127:0] k,
    input logic [7:0]   rc
  );
    logic [31:0] t, w4, w5, w6, w7;
    t  = {sbox(k[23:16]), sbox(k[15:8]),
          sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    w4 = k[127:96] ^ t;
    w5 = k[95:64] ^ w4;
    w6 = k[63:32] ^ w5;
    w7 = k[31:0] ^ w6;
    return {w4, w5, w6, w7};
  endfunction

  assign next_key = key_exp(key_reg, rcon(rnd));
  assign sr       = sub_shift(state_reg);

  always_comb begin
    fsm_nx   = fsm;
    state_nx = state_reg;
    key_nx   = key_reg;
    rnd_nx   = rnd;
    out_nx   = AES_data_out;
    vld_nx   = 1'b0;
    unique case (fsm)
      IDLE: begin
        if (AES_en) begin
          state_nx = AES_data_in ^ AES_key_in;
          key_nx   = AES_key_in;
          rnd_nx   = 4'd1;
          fsm_nx   = BUSY;
        end
      end
      BUSY: begin
        key_nx = next_key;
        rnd_nx = rnd + 4'd1;
        if (rnd == 4'd10) begin
          out_nx = sr ^ next_key;
          vld_nx = 1'b1;
          fsm_nx = IDLE;
        end else begin
          state_nx = mix(sr) ^ next_key;
        end
      end
      default: fsm_nx = IDLE;
    endcase
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      fsm                <= IDLE;
      state_reg          <= '0;
      key_reg            <= '0;
      rnd                <= '0;
      AES_data_out       <= '0;
      AES_data_out_valid <= 1'b0;
    end else begin
      fsm                <= fsm_nx;
      state_reg          <= state_nx;
      key_reg            <= key_nx;
      rnd                <= rnd_nx;
      AES_data_out       <= out_nx;
      AES_data_out_valid <= vld_nx;
    end
  end

endmodule

// File: tb/tb_aes_top.sv
// Self-checking bench for aes_top.
// Known-answer table plus scoreboard-driven corner sequences.
module tb_aes_top;

  localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1D = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct packed {
    logic [127:0] key;
    logic [127:0] data;
    logic [127:0] expd;
    logic [127:0] r1;
    logic         chk_r1;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [127:0] din = '0;
  logic [127:0] kin = '0;
  logic [127:0] dout;
  logic         vld;

  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] sb_q[$];

  always #5 clk = ~clk;

  aes_top dut (
    .AES_clk            (clk),
    .AES_rst_n          (rst_n),
    .AES_en             (en),
    .AES_data_in        (din),
    .AES_key_in         (kin),
    .AES_data_out       (dout),
    .AES_data_out_valid (vld)
  );

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  always @(negedge clk) begin
    if (rst_n && vld) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got pulse %h want none", dout);
      end else begin
        chk("sb_data", dout, sb_q.pop_front());
      end
    end
  end

  task automatic run_one(input vec_t v);
    int lat;
    int np;
    lat = -1;
    np  = 0;
    @(negedge clk);
    en  = 1'b1;
    din = v.data;
    kin = v.key;
    sb_q.push_back(v.expd);
    @(negedge clk);
    en  = 1'b0;
    din = rnd128();
    kin = rnd128();
    chk("ark", dut.state_reg, v.data ^ v.key);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1 && v.chk_r1) chk("round1", dut.state_reg, v.r1);
      if (vld) begin
        np++;
        if (lat < 0) lat = i;
      end
    end
    chk("latency", 128'(lat), 128'd10);
    chk("pulses", 128'(np), 128'd1);
    chk("hold", dout, v.expd);
  endtask

  initial begin
    vec_t tv[3];
    int   prev;
    int   np;
    int   lat;

    tv[0] = '{C1K, C1D, C1C, 128'h0, 1'b0};
    tv[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
              128'h3243f6a8885a308d313198a2e0370734,
              128'h3925841d02dc09fbdc118597196a0b32,
              128'ha49c7ff2689f352b6b5bea43026a5049, 1'b1};
    tv[2] = '{128'h0, 128'h0,
              128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
              128'h0, 1'b0};

    #12;
    chk("rst_dout", dout, 128'h0);
    chk("rst_vld", 128'(vld), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 3; t++) run_one(tv[t]);

    // AES_en held high for 51 edges
    @(negedge clk);
    en  = 1'b1;
    din = C1D;
    kin = C1K;
    repeat (5) sb_q.push_back(C1C);
    prev = -1;
    np   = 0;
    for (int i = 0; i <= 50; i++) begin
      @(negedge clk);
      if (vld) begin
        np++;
        if (prev >= 0) chk("b2b_gap", 128'(i - prev), 128'd11);
        else chk("b2b_first", 128'(i), 128'd10);
        prev = i;
      end else if (prev >= 0) begin
        chk("b2b_stable", dout, C1C);
      end
    end
    chk("b2b_pulses", 128'(np), 128'd4);
    en  = 1'b0;
    din = rnd128();
    kin = rnd128();
    np  = 0;
    for (int i = 51; i <= 65; i++) begin
      @(negedge clk);
      if (vld) np++;
    end
    chk("b2b_tail", 128'(np), 128'd1);
    chk("b2b_hold", dout, C1C);

    // input change and AES_en pulses mid-encryption
    @(negedge clk);
    en  = 1'b1;
    din = C1D;
    kin = C1K;
    sb_q.push_back(C1C);
    @(negedge clk);
    en  = 1'b0;
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 3) begin
        din = rnd128();
        kin = rnd128();
        en  = 1'b1;
      end
      if (i == 5) en = 1'b0;
      if (vld && lat < 0) lat = i;
    end
    chk("mid_latency", 128'(lat), 128'd10);
    chk("mid_hold", dout, C1C);

    // reset in flight
    @(negedge clk);
    en  = 1'b1;
    din = C1D;
    kin = C1K;
    @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_dout", dout, 128'h0);
    chk("arst_vld", 128'(vld), 128'h0);
    chk("arst_state", dut.state_reg, 128'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    np = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (vld) np++;
    end
    chk("arst_nopulse", 128'(np), 128'd0);
    run_one(tv[0]);

    repeat (2) @(negedge clk);
    chk("sb_empty", 128'(sb_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
